// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for C = A x B with K fixed at 8. It walks the 8x8 output tiles
// row-major and starts the systolic-array driver once per tile. When the driver
// finishes, the tile result is captured and written back one 8-word row per handshake.
// sa_Out packing: element [r][c] occupies bits [(r*8+c)*DATA_WIDTH +: DATA_WIDTH].
// wr_data packing: word c of the row occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
module matmul_tile_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_A,
  input  logic [ADDR_WIDTH-1:0]      base_B,
  input  logic [ADDR_WIDTH-1:0]      base_C,
  input  logic [DIM_WIDTH-1:0]       rows_A,
  input  logic [DIM_WIDTH-1:0]       cols_B,
  input  logic [DIM_WIDTH-1:0]       dim_col_A,
  input  logic [DIM_WIDTH-1:0]       dim_col_B,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       sa_start,
  output logic [ADDR_WIDTH-1:0]      sa_base_A,
  output logic [ADDR_WIDTH-1:0]      sa_base_B,
  output logic [DIM_WIDTH-1:0]       sa_dim_A,
  output logic [DIM_WIDTH-1:0]       sa_dim_B,
  input  logic                       sa_done,
  input  logic [64*DATA_WIDTH-1:0]   sa_Out,
  output logic                       wr_req,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [8*DATA_WIDTH-1:0]    wr_data,
  input  logic                       wr_ack
);

  // Tile edge is tied to the driver's array size.
  localparam int unsigned TILE      = 8;
  localparam int unsigned TILE_LOG2 = 3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitSa,
    StWrite,
    StNext,
    StFin
  } state_t;

  state_t state_q, state_d;

  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   a_row_q;      // base_A + ti*8*dim_col_A
  logic [ADDR_WIDTH-1:0]   base_b_q;
  logic [ADDR_WIDTH-1:0]   col_off_q;    // tj*8
  logic [ADDR_WIDTH-1:0]   c_tilerow_q;  // base_C + ti*8*cols_B
  logic [ADDR_WIDTH-1:0]   a_step_q;     // 8*dim_col_A
  logic [ADDR_WIDTH-1:0]   c_step_q;     // 8*cols_B
  logic [ADDR_WIDTH-1:0]   cols_q;
  logic [DIM_WIDTH-1:0]    dim_a_q;
  logic [DIM_WIDTH-1:0]    dim_b_q;
  logic [DIM_WIDTH-1:0]    tm_q;
  logic [DIM_WIDTH-1:0]    tn_q;
  logic [DIM_WIDTH-1:0]    ti_q;
  logic [DIM_WIDTH-1:0]    tj_q;
  logic [2:0]              r_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [8*DATA_WIDTH-1:0] buf_q [8];

  logic accept;
  logic cmd_ok;
  logic last_tile;
  logic last_col;

  assign accept    = (state_q == StIdle) && start;
  assign cmd_ok    = (rows_A != '0) && (rows_A[TILE_LOG2-1:0] == '0) &&
                     (cols_B != '0) && (cols_B[TILE_LOG2-1:0] == '0);
  assign last_col  = (tj_q == tn_q - DIM_WIDTH'(1));
  assign last_tile = last_col && (ti_q == tm_q - DIM_WIDTH'(1));

  assign busy      = (state_q != StIdle);
  assign err       = err_q;
  assign sa_base_A = a_row_q;
  assign sa_base_B = base_b_q + col_off_q;
  assign sa_dim_A  = dim_a_q;
  assign sa_dim_B  = dim_b_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = buf_q[r_q];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_d  = state_q;
    sa_start = 1'b0;
    wr_req   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:   if (start) state_d = cmd_ok ? StIssue : StFin;
      StIssue: begin
        sa_start = 1'b1;
        state_d  = StWaitSa;
      end
      StWaitSa: if (sa_done) state_d = StWrite;
      StWrite: begin
        wr_req = 1'b1;
        if (wr_ack && (r_q == 3'd7)) state_d = StNext;
      end
      StNext:   state_d = last_tile ? StFin : StIssue;
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Command latch and tile-walk counters; addresses advance by addition only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      a_row_q     <= '0;
      base_b_q    <= '0;
      col_off_q   <= '0;
      c_tilerow_q <= '0;
      a_step_q    <= '0;
      c_step_q    <= '0;
      cols_q      <= '0;
      dim_a_q     <= '0;
      dim_b_q     <= '0;
      tm_q        <= '0;
      tn_q        <= '0;
      ti_q        <= '0;
      tj_q        <= '0;
    end else if (accept) begin
      err_q       <= !cmd_ok;
      a_row_q     <= base_A;
      base_b_q    <= base_B;
      col_off_q   <= '0;
      c_tilerow_q <= base_C;
      a_step_q    <= ADDR_WIDTH'(dim_col_A) << TILE_LOG2;
      c_step_q    <= ADDR_WIDTH'(cols_B) << TILE_LOG2;
      cols_q      <= ADDR_WIDTH'(cols_B);
      dim_a_q     <= dim_col_A;
      dim_b_q     <= dim_col_B;
      tm_q        <= rows_A >> TILE_LOG2;
      tn_q        <= cols_B >> TILE_LOG2;
      ti_q        <= '0;
      tj_q        <= '0;
    end else if ((state_q == StNext) && !last_tile) begin
      // Counters freeze on the final tile so the bases stay put after done.
      if (last_col) begin
        tj_q        <= '0;
        col_off_q   <= '0;
        ti_q        <= ti_q + DIM_WIDTH'(1);
        a_row_q     <= a_row_q + a_step_q;
        c_tilerow_q <= c_tilerow_q + c_step_q;
      end else begin
        tj_q      <= tj_q + DIM_WIDTH'(1);
        col_off_q <= col_off_q + ADDR_WIDTH'(TILE);
      end
    end
  end

  // Tile capture and row write-back sequencing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      wr_addr_q <= '0;
      for (int r = 0; r < 8; r++) buf_q[r] <= '0;
    end else if ((state_q == StWaitSa) && sa_done) begin
      r_q       <= '0;
      wr_addr_q <= c_tilerow_q + col_off_q;
      for (int r = 0; r < 8; r++) buf_q[r] <= sa_Out[r*8*DATA_WIDTH +: 8*DATA_WIDTH];
    end else if ((state_q == StWrite) && wr_ack) begin
      r_q       <= r_q + 3'd1;
      wr_addr_q <= wr_addr_q + cols_q;
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: single tiles, a 2x3 tile walk,
// throttled write acks with address wrap, bad dimensions and a mid-write reset.
module tb_matmul_tile_scheduler;

  logic          clock;
  logic          reset;
  logic          start;
  logic [15:0]   base_A, base_B, base_C;
  logic [15:0]   rows_A, cols_B, dim_col_A, dim_col_B;
  logic          busy, done, err, sa_start;
  logic [15:0]   sa_base_A, sa_base_B, sa_dim_A, sa_dim_B;
  logic          sa_done;
  logic [1023:0] sa_Out;
  logic          wr_req;
  logic [15:0]   wr_addr;
  logic [127:0]  wr_data;
  logic          wr_ack;

  int checks = 0;
  int errors = 0;
  int sa_cnt = 0;
  int wr_cnt = 0;
  int sa_base_cnt, wr_base_cnt;

  matmul_tile_scheduler #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DIM_WIDTH (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_A   (base_A),
    .base_B   (base_B),
    .base_C   (base_C),
    .rows_A   (rows_A),
    .cols_B   (cols_B),
    .dim_col_A(dim_col_A),
    .dim_col_B(dim_col_B),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sa_start (sa_start),
    .sa_base_A(sa_base_A),
    .sa_base_B(sa_base_B),
    .sa_dim_A (sa_dim_A),
    .sa_dim_B (sa_dim_B),
    .sa_done  (sa_done),
    .sa_Out   (sa_Out),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pre-edge values at each rising edge: driver starts and accepted row writes.
  always @(posedge clock) begin
    if (!reset) begin
      if (sa_start) sa_cnt++;
      if (wr_req && wr_ack) wr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Element [r][c] of a tile result = {seed, r, c}.
  function automatic logic [127:0] row_word(input int seed, input int r);
    logic [127:0] v;
    for (int c = 0; c < 8; c++) v[c*16 +: 16] = {8'(seed), 4'(r), 4'(c)};
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " sa_start"}, sa_start, 0);
    check({tag, " sa_base_A"}, sa_base_A, 0);
    check({tag, " sa_base_B"}, sa_base_B, 0);
    check({tag, " wr_req"}, wr_req, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
  endtask

  task automatic do_start(input logic [15:0] m, n, ba, bb, bc, da, db);
    rows_A = m; cols_B = n; base_A = ba; base_B = bb; base_C = bc;
    dim_col_A = da; dim_col_B = db;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one tile from ISSUE through the last row ack; returns in the NEXT cycle.
  task automatic run_tile(input int seed, input logic [15:0] exp_a, exp_b, exp_c0, stride,
                          input int gap, input int abort_row, input bit disturb);
    bit            found;
    logic [1023:0] tile;
    logic [15:0]   exp_addr;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sa_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("sa_start seen", found, 1);
    if (!found) return;
    check("sa_base_A", sa_base_A, exp_a);
    check("sa_base_B", sa_base_B, exp_b);
    for (int r = 0; r < 8; r++) tile[r*128 +: 128] = row_word(seed, r);
    tick();
    check("sa_start one cycle", sa_start, 0);
    check("no wr_req while driver runs", wr_req, 0);
    for (int i = 0; i < 2; i++) begin
      if (disturb) begin
        rows_A = 16'd16; cols_B = 16'd8;
        base_A = 16'h1111; base_B = 16'h2222; base_C = 16'h3333;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    sa_Out  = tile;
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    sa_Out  = ~tile;
    exp_addr = exp_c0;
    for (int r = 0; r < 8; r++) begin
      check("wr_req", wr_req, 1);
      check("wr_addr", wr_addr, exp_addr);
      check("wr_data", wr_data, row_word(seed, r));
      if (r == abort_row) begin
        reset = 1'b1;
        #1;
        check_idle_zero("async reset");
        wr_ack = 1'b0;
        return;
      end
      if (disturb && r == 4) begin
        wr_ack  = 1'b0;
        start   = 1'b1;
        sa_done = 1'b1;
        tick();
        start   = 1'b0;
        sa_done = 1'b0;
        check("wr_addr after stray start", wr_addr, exp_addr);
        check("wr_data after stray sa_done", wr_data, row_word(seed, r));
      end
      for (int g = 0; g < gap; g++) begin
        wr_ack = 1'b0;
        tick();
        check("wr_addr hold", wr_addr, exp_addr);
        check("wr_data hold", wr_data, row_word(seed, r));
      end
      wr_ack = 1'b1;
      tick();
      exp_addr = exp_addr + stride;
    end
    wr_ack = 1'b0;
    check("NEXT wr_req low", wr_req, 0);
    check("NEXT busy", busy, 1);
  endtask

  // Called in the NEXT cycle of the final tile: FIN follows, then IDLE.
  task automatic expect_done(input string tag);
    tick();
    check({tag, " done"}, done, 1);
    check({tag, " err"}, err, 0);
    check({tag, " busy in FIN"}, busy, 1);
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy low"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sa_done = 1'b0; sa_Out = '0; wr_ack = 1'b0;
    base_A = '0; base_B = '0; base_C = '0;
    rows_A = '0; cols_B = '0; dim_col_A = '0; dim_col_B = '0;
    tick();
    tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    // Single tile: bases 0/100/200, strides 8, ack every cycle.
    sa_base_cnt = sa_cnt; wr_base_cnt = wr_cnt;
    do_start(16'd8, 16'd8, 16'd0, 16'd100, 16'd200, 16'd8, 16'd8);
    check("busy after start", busy, 1);
    run_tile(1, 16'd0, 16'd100, 16'd200, 16'd8, 0, -1, 1'b0);
    expect_done("8x8");
    check("8x8 sa_start count", sa_cnt - sa_base_cnt, 1);
    check("8x8 write count", wr_cnt - wr_base_cnt, 8);

    // 16x24: six tiles row-major; stray start/sa_done pulses on tile (0,1).
    sa_base_cnt = sa_cnt; wr_base_cnt = wr_cnt;
    do_start(16'd16, 16'd24, 16'd1000, 16'd2000, 16'd3000, 16'd8, 16'd24);
    check("sa_dim_A", sa_dim_A, 16'd8);
    check("sa_dim_B", sa_dim_B, 16'd24);
    for (int ti = 0; ti < 2; ti++) begin
      for (int tj = 0; tj < 3; tj++) begin
        run_tile(ti * 16 + tj, 16'(1000 + ti * 64), 16'(2000 + tj * 8),
                 16'(3000 + ti * 8 * 24 + tj * 8), 16'd24, 0, -1, (ti == 0 && tj == 1));
        if (!(ti == 1 && tj == 2)) check("no done mid-walk", done, 0);
      end
    end
    expect_done("16x24");
    check("16x24 sa_start count", sa_cnt - sa_base_cnt, 6);
    check("16x24 write count", wr_cnt - wr_base_cnt, 48);

    // Throttled acks (3 idle cycles per row) and C addresses wrapping past 0xFFFF.
    sa_base_cnt = sa_cnt; wr_base_cnt = wr_cnt;
    do_start(16'd8, 16'd8, 16'h0400, 16'h0500, 16'hFFF0, 16'd8, 16'd8);
    run_tile(7, 16'h0400, 16'h0500, 16'hFFF0, 16'd8, 3, -1, 1'b0);
    expect_done("throttled");
    check("throttled write count", wr_cnt - wr_base_cnt, 8);

    // M not a multiple of 8: done+err on the next cycle, nothing issued.
    sa_base_cnt = sa_cnt; wr_base_cnt = wr_cnt;
    do_start(16'd12, 16'd8, 16'd0, 16'd0, 16'd0, 16'd8, 16'd8);
    check("bad M done", done, 1);
    check("bad M err", err, 1);
    check("bad M no sa_start", sa_start, 0);
    check("bad M no wr_req", wr_req, 0);
    tick();
    check("bad M done one cycle", done, 0);
    check("bad M busy low", busy, 0);
    check("bad M err held", err, 1);
    // N zero is rejected the same way.
    do_start(16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd8, 16'd8);
    check("N zero done", done, 1);
    check("N zero err", err, 1);
    tick();
    check("bad dims sa_start count", sa_cnt - sa_base_cnt, 0);
    check("bad dims write count", wr_cnt - wr_base_cnt, 0);

    // Reset during row 3, then a fresh start re-runs tile (0,0) and clears err.
    do_start(16'd8, 16'd8, 16'd50, 16'd60, 16'd70, 16'd8, 16'd8);
    check("err cleared by valid start", err, 0);
    run_tile(3, 16'd50, 16'd60, 16'd70, 16'd8, 0, 3, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("after reset busy", busy, 0);
    check("after reset wr_req", wr_req, 0);
    sa_base_cnt = sa_cnt; wr_base_cnt = wr_cnt;
    do_start(16'd8, 16'd8, 16'd50, 16'd60, 16'd70, 16'd8, 16'd8);
    run_tile(4, 16'd50, 16'd60, 16'd70, 16'd8, 0, -1, 1'b0);
    expect_done("rerun");
    check("rerun sa_start count", sa_cnt - sa_base_cnt, 1);
    check("rerun write count", wr_cnt - wr_base_cnt, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
